// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying one FIFO word per beat, framed by a last-beat flag.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input  m_ready);
    modport slave  (input  m_valid, input  m_data, input  m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a registered-output FIFO read port into a framed valid/ready stream
// through a 2-entry buffer, sustaining one beat per cycle.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PKT_LEN    = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  flush,
    fifo_stream_reader_if.master  m,
    output logic [CNT_WIDTH-1:0]  pkt_count
);

    localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic [1:0]            occ_q, occ_n;
    logic                  inflight_q;
    logic [BEAT_W-1:0]     beat_q, beat_n;
    logic [DATA_WIDTH-1:0] head_q, head_n, tail_q, tail_n;
    logic [CNT_WIDTH-1:0]  pkt_n;
    logic                  pop, capture;
    logic [1:0]            demand;

    assign pop     = m.m_valid && m.m_ready;
    assign capture = inflight_q && !flush;

    // Words already owned (buffered or in flight) after this cycle's pop; read only if one slot stays free.
    assign demand     = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && !flush && !demand[1];

    // Buffer ordering, occupancy, beat position and packet count.
    always_comb begin
        occ_n  = occ_q;
        head_n = head_q;
        tail_n = tail_q;
        beat_n = beat_q;
        pkt_n  = pkt_count;
        if (flush) begin
            occ_n  = 2'd0;
            beat_n = '0;
        end else begin
            case ({capture, pop})
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_n = fifo_dout;
                    end else begin
                        head_n = tail_q;
                        tail_n = fifo_dout;
                    end
                end
                2'b01: begin
                    head_n = tail_q;
                    occ_n  = occ_q - 2'd1;
                end
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_n = fifo_dout;
                    end else begin
                        tail_n = fifo_dout;
                    end
                    occ_n = occ_q + 2'd1;
                end
                default: ;
            endcase
            if (pop) begin
                beat_n = (beat_q == LAST_BEAT) ? '0 : beat_q + BEAT_W'(1);
                if (m.m_last) begin
                    pkt_n = pkt_count + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Stream outputs are registered copies of next-state so nothing depends on m_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            pkt_count  <= '0;
            m.m_valid  <= 1'b0;
            m.m_data   <= '0;
            m.m_last   <= 1'b0;
        end else begin
            occ_q      <= occ_n;
            inflight_q <= fifo_rd_en;
            beat_q     <= beat_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            pkt_count  <= pkt_n;
            m.m_valid  <= (occ_n != 2'd0);
            m.m_data   <= head_n;
            m.m_last   <= (occ_n != 2'd0) && (beat_n == LAST_BEAT);
        end
    end

    occ_bound: assert property (@(posedge clk) disable iff (!rst_n) occ_q != 2'd3);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: streaming, backpressure, empty, flush, wrap, async reset.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    // DUT0: PKT_LEN=4, CNT_WIDTH=16
    logic        fifo_empty0, rd_en0, flush0;
    logic [7:0]  dout0;
    logic [15:0] pkt0;
    logic [7:0]  mem0 [0:63];
    logic [5:0]  wr0 = '0, rd0 = '0;
    fifo_stream_reader_if #(.DATA_WIDTH(8)) s0 ();

    fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(4), .CNT_WIDTH(16)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty0),
        .fifo_rd_en (rd_en0),
        .fifo_dout  (dout0),
        .flush      (flush0),
        .m          (s0.master),
        .pkt_count  (pkt0)
    );

    assign fifo_empty0 = (wr0 == rd0);
    always @(posedge clk) begin
        if (rd_en0 && !fifo_empty0) begin
            dout0 <= mem0[rd0];
            rd0   <= rd0 + 6'd1;
        end
    end

    // DUT1: PKT_LEN=1, CNT_WIDTH=2
    logic        fifo_empty1, rd_en1, flush1;
    logic [7:0]  dout1;
    logic [1:0]  pkt1;
    logic [7:0]  mem1 [0:63];
    logic [5:0]  wr1 = '0, rd1 = '0;
    fifo_stream_reader_if #(.DATA_WIDTH(8)) s1 ();

    fifo_stream_reader #(.DATA_WIDTH(8), .PKT_LEN(1), .CNT_WIDTH(2)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty1),
        .fifo_rd_en (rd_en1),
        .fifo_dout  (dout1),
        .flush      (flush1),
        .m          (s1.master),
        .pkt_count  (pkt1)
    );

    assign fifo_empty1 = (wr1 == rd1);
    always @(posedge clk) begin
        if (rd_en1 && !fifo_empty1) begin
            dout1 <= mem1[rd1];
            rd1   <= rd1 + 6'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push0(input logic [7:0] d);
        mem0[wr0] = d;
        wr0 = wr0 + 6'd1;
    endtask

    task automatic push1(input logic [7:0] d);
        mem1[wr1] = d;
        wr1 = wr1 + 6'd1;
    endtask

    task automatic wait_valid0(input string tag);
        int n = 0;
        while (!s0.m_valid && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(s0.m_valid), 32'd1);
    endtask

    task automatic wait_valid1(input string tag);
        int n = 0;
        while (!s1.m_valid && n < 10) begin
            step();
            n++;
        end
        chk(tag, 32'(s1.m_valid), 32'd1);
    endtask

    initial begin
        int k, outstanding, cnt_rd, cnt_v;
        logic stall_prev, pop;
        logic [7:0] data_prev;
        int wrap_exp [5] = '{1, 2, 3, 0, 1};

        rst_n = 1'b0; flush0 = 1'b0; flush1 = 1'b0;
        s0.m_ready = 1'b0; s1.m_ready = 1'b0;
        #12;
        for (int i = 0; i < 8; i++) push0(8'h10 + 8'(i));
        #1;
        chk("rst_valid", 32'(s0.m_valid), 32'd0);
        chk("rst_data",  32'(s0.m_data),  32'd0);
        chk("rst_last",  32'(s0.m_last),  32'd0);
        chk("rst_pkt",   32'(pkt0),       32'd0);
        chk("rst_rden",  32'(rd_en0),     32'd0);

        // Streaming with PKT_LEN=4
        step();
        s0.m_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("str_rden_c0", 32'(rd_en0), 32'd1);
        step();
        chk("str_valid_c1", 32'(s0.m_valid), 32'd0);
        step();
        for (int i = 0; i < 8; i++) begin
            chk("str_valid", 32'(s0.m_valid), 32'd1);
            chk("str_data",  32'(s0.m_data),  32'h10 + 32'(i));
            chk("str_last",  32'(s0.m_last),  32'((i % 4) == 3));
            step();
        end
        chk("str_valid_end", 32'(s0.m_valid), 32'd0);
        chk("str_pkt",       32'(pkt0),       32'd2);

        // Backpressure, ready pattern 1,0,0,1
        for (int i = 0; i < 8; i++) push0(8'h20 + 8'(i));
        k = 0; outstanding = 0; stall_prev = 1'b0; data_prev = '0;
        for (int c = 0; c < 80 && k < 8; c++) begin
            s0.m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            #1;
            pop = s0.m_valid && s0.m_ready;
            if (s0.m_valid) begin
                chk("bp_data", 32'(s0.m_data), 32'h20 + 32'(k));
                chk("bp_last", 32'(s0.m_last), 32'((k % 4) == 3));
            end
            if (stall_prev) chk("bp_hold", 32'(s0.m_data), 32'(data_prev));
            chk("bp_owned", 32'(outstanding <= 2), 32'd1);
            if (outstanding - int'(pop) > 1) chk("bp_rden_block", 32'(rd_en0), 32'd0);
            outstanding = outstanding + int'(rd_en0) - int'(pop);
            k = k + int'(pop);
            stall_prev = s0.m_valid && !s0.m_ready;
            data_prev  = s0.m_data;
            step();
        end
        chk("bp_count", 32'(k), 32'd8);
        chk("bp_pkt", 32'(pkt0), 32'd4);
        s0.m_ready = 1'b1;
        step();
        chk("bp_drained", 32'(s0.m_valid), 32'd0);

        // Single word into an empty FIFO
        step();
        chk("emp_rden_idle", 32'(rd_en0), 32'd0);
        push0(8'hA5);
        cnt_rd = 0; cnt_v = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            cnt_rd += int'(rd_en0);
            cnt_v  += int'(s0.m_valid);
            if (s0.m_valid) chk("emp_data", 32'(s0.m_data), 32'hA5);
            step();
        end
        chk("emp_rd_once",    32'(cnt_rd), 32'd1);
        chk("emp_valid_once", 32'(cnt_v),  32'd1);

        // Flush with a full buffer and one word in flight
        s0.m_ready = 1'b0;
        for (int i = 1; i <= 7; i++) push0(8'(i));
        repeat (4) step();
        chk("fl_full_valid", 32'(s0.m_valid), 32'd1);
        chk("fl_full_data",  32'(s0.m_data),  32'h01);
        chk("fl_full_rden",  32'(rd_en0),     32'd0);
        s0.m_ready = 1'b1;
        #1;
        chk("fl_pop_rden", 32'(rd_en0), 32'd1);
        step();
        s0.m_ready = 1'b0;
        flush0 = 1'b1;
        #1;
        chk("fl_rden_blocked", 32'(rd_en0), 32'd0);
        step();
        flush0 = 1'b0;
        chk("fl_valid_clr", 32'(s0.m_valid), 32'd0);
        chk("fl_last_clr",  32'(s0.m_last),  32'd0);
        chk("fl_pkt_kept",  32'(pkt0),       32'd4);
        s0.m_ready = 1'b1;
        wait_valid0("fl_restart_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("fl_data", 32'(s0.m_data), 32'h04 + 32'(i));
            chk("fl_last", 32'(s0.m_last), 32'(i == 3));
            step();
        end
        chk("fl_pkt_after", 32'(pkt0), 32'd5);

        // Counter wrap on DUT1 (PKT_LEN=1, CNT_WIDTH=2)
        for (int i = 0; i < 5; i++) push1(8'h40 + 8'(i));
        s1.m_ready = 1'b1;
        wait_valid1("wrap_timeout");
        for (int i = 0; i < 5; i++) begin
            chk("wrap_data", 32'(s1.m_data), 32'h40 + 32'(i));
            chk("wrap_last", 32'(s1.m_last), 32'd1);
            step();
            chk("wrap_pkt", 32'(pkt1), 32'(wrap_exp[i]));
        end

        // Async reset mid-packet with occ=2
        for (int i = 0; i < 8; i++) push0(8'h30 + 8'(i));
        s0.m_ready = 1'b1;
        wait_valid0("ar_timeout");
        chk("ar_data0", 32'(s0.m_data), 32'h30);
        step();
        chk("ar_data1", 32'(s0.m_data), 32'h31);
        step();
        s0.m_ready = 1'b0;
        step();
        step();
        chk("ar_hold_valid", 32'(s0.m_valid), 32'd1);
        chk("ar_hold_data",  32'(s0.m_data),  32'h32);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(s0.m_valid), 32'd0);
        chk("ar_last",  32'(s0.m_last),  32'd0);
        chk("ar_pkt",   32'(pkt0),       32'd0);
        chk("ar_rden",  32'(rd_en0),     32'd0);
        #2;
        rst_n = 1'b1;
        s0.m_ready = 1'b1;
        wait_valid0("ar_restart_timeout");
        for (int i = 0; i < 4; i++) begin
            chk("ar_post_data", 32'(s0.m_data), 32'h34 + 32'(i));
            chk("ar_post_last", 32'(s0.m_last), 32'(i == 3));
            step();
        end
        chk("ar_post_pkt", 32'(pkt0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
